// File: rtl/vga_tile_pkg.sv
// ---------------------------------------------------------------------------
// vga_tile_pkg
// Shared definitions for the VGA tile scanner and the tile texture stage:
//   - 640x480@60 Hz raster timing (visible, porch and sync widths, totals)
//   - tile geometry (32x32 tiles, 512-pixel-wide playfield)
//   - the 4-bit tile-code enum stored in the map RAM
// ---------------------------------------------------------------------------
package vga_tile_pkg;

  // Horizontal timing, in pixel clocks
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;  // 800

  // Vertical timing, in lines
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;  // 525

  // Counter width covering both totals
  localparam int CNT_W = 10;

  // Tile geometry
  localparam int TILE_SHIFT  = 5;    // 32x32 pixel tiles
  localparam int PLAYFIELD_W = 512;  // 16 tile columns

  // Tile codes as stored in the map RAM
  typedef enum logic [3:0] {
    TILE_GROUND  = 4'd0,
    TILE_FOOD    = 4'd1,
    TILE_BODY_H  = 4'd2,
    TILE_BODY_V  = 4'd3,
    TILE_BODY_LU = 4'd4,
    TILE_BODY_LD = 4'd5,
    TILE_BODY_RU = 4'd6,
    TILE_BODY_RD = 4'd7,
    TILE_TAIL_L  = 4'd8,
    TILE_TAIL_R  = 4'd9,
    TILE_TAIL_U  = 4'd10,
    TILE_TAIL_D  = 4'd11,
    TILE_HEAD_L  = 4'd12,
    TILE_HEAD_R  = 4'd13,
    TILE_HEAD_U  = 4'd14,
    TILE_HEAD_D  = 4'd15
  } tile_e;

  // The texture stage takes a 5-bit type; the top bit is reserved.
  function automatic logic [4:0] tile_to_type(input tile_e t);
    return {1'b0, t};
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// ---------------------------------------------------------------------------
// vga_sync_counter
// Free-running 640x480@60 raster counters plus first-stage timing flags.
// Ports:
//   i_clk          pixel clock (25 MHz)
//   i_rst          synchronous active-high reset
//   o_h_cnt        horizontal counter 0..799 (stage 0)
//   o_v_cnt        vertical counter 0..524 (stage 0)
//   o_hsync_raw    active-low hsync, registered from the counters (stage 1)
//   o_vsync_raw    active-low vsync, registered from the counters (stage 1)
//   o_active       visible-area flag, registered from the counters (stage 1)
//   o_frame_tick   one-cycle pulse while the counters sit at h=0, v=480
// ---------------------------------------------------------------------------
module vga_sync_counter
  import vga_tile_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_hsync_raw,
  output logic             o_vsync_raw,
  output logic             o_active,
  output logic             o_frame_tick
);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_hsync_raw;
  logic             r_vsync_raw;
  logic             r_active;
  logic             r_frame_tick;

  logic             w_h_wrap;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;

  always_comb begin
    w_h_wrap = (r_h_cnt == CNT_W'(H_TOTAL - 1));
    w_h_next = w_h_wrap ? '0 : r_h_cnt + CNT_W'(1);
    w_v_next = r_v_cnt;
    if (w_h_wrap) begin
      w_v_next = (r_v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : r_v_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_hsync_raw  <= 1'b1;
      r_vsync_raw  <= 1'b1;
      r_active     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_h_cnt      <= w_h_next;
      r_v_cnt      <= w_v_next;
      r_hsync_raw  <= !((r_h_cnt >= CNT_W'(H_VIS + H_FP)) &&
                        (r_h_cnt <  CNT_W'(H_VIS + H_FP + H_SYNC)));
      r_vsync_raw  <= !((r_v_cnt >= CNT_W'(V_VIS + V_FP)) &&
                        (r_v_cnt <  CNT_W'(V_VIS + V_FP + V_SYNC)));
      r_active     <= (r_h_cnt < CNT_W'(H_VIS)) && (r_v_cnt < CNT_W'(V_VIS));
      // Decoded from the next count so the pulse coincides with h=0, v=480.
      r_frame_tick <= (w_h_next == '0) && (w_v_next == CNT_W'(V_VIS));
    end
  end

  assign o_h_cnt      = r_h_cnt;
  assign o_v_cnt      = r_v_cnt;
  assign o_hsync_raw  = r_hsync_raw;
  assign o_vsync_raw  = r_vsync_raw;
  assign o_active     = r_active;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: rtl/vga_tile_scan.sv
// ---------------------------------------------------------------------------
// vga_tile_scan
// Raster scanner and tile fetcher for the tile texture stage.
// Optional feature macro: VGA_TILE_SCAN_BORDER_EN (right-hand strip h=512..639
// flagged on o_border and painted as ground). Undefined: o_border stays 0 and
// the strip repeats map columns 0..3.
// Ports:
//   i_vgaclk      25 MHz pixel clock
//   i_rst         synchronous active-high reset
//   o_map_addr    map RAM address {map_y, map_x}, 1 cycle after the counters
//   i_map_data    map RAM data, valid 1 cycle after o_map_addr
//   o_type        tile type {1'b0, code}, 2 cycles after the counters
//   o_x_pos       column within tile, 2 cycles after the counters
//   o_y_pos       row within tile, 2 cycles after the counters
//   o_hsync       active-low hsync, 3 cycles after the counters
//   o_vsync       active-low vsync, 3 cycles after the counters
//   o_de          display enable, 3 cycles after the counters
//   o_border      right-hand strip flag, 3 cycles after the counters
//   o_frame_tick  one-cycle pulse at the start of vertical blanking
// ---------------------------------------------------------------------------
module vga_tile_scan
  import vga_tile_pkg::*;
(
  input  logic       i_vgaclk,
  input  logic       i_rst,
  output logic [7:0] o_map_addr,
  input  logic [3:0] i_map_data,
  output logic [4:0] o_type,
  output logic [4:0] o_x_pos,
  output logic [4:0] o_y_pos,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de,
  output logic       o_border,
  output logic       o_frame_tick
);

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_hsync_raw;
  logic             w_vsync_raw;
  logic             w_active;
  logic [3:0]       w_map_y;
  logic             w_in_border;

  vga_sync_counter u_counter (
    .i_clk        (i_vgaclk),
    .i_rst        (i_rst),
    .o_h_cnt      (w_h_cnt),
    .o_v_cnt      (w_v_cnt),
    .o_hsync_raw  (w_hsync_raw),
    .o_vsync_raw  (w_vsync_raw),
    .o_active     (w_active),
    .o_frame_tick (o_frame_tick)
  );

  // Rows 480..511 would decode to map_y=15, which does not exist; during
  // vertical blanking the fetch parks on row 0 instead.
  assign w_map_y = (w_v_cnt < CNT_W'(V_VIS)) ? w_v_cnt[TILE_SHIFT +: 4] : 4'd0;

`ifdef VGA_TILE_SCAN_BORDER_EN
  assign w_in_border = (w_h_cnt >= CNT_W'(PLAYFIELD_W)) &&
                       (w_h_cnt <  CNT_W'(H_VIS)) &&
                       (w_v_cnt <  CNT_W'(V_VIS));
`else
  assign w_in_border = 1'b0;
  logic w_unused;
  assign w_unused = w_h_cnt[CNT_W-1];
`endif

  // Stage 1 (alongside the raw syncs inside the counter)
  logic [7:0] r_map_addr;
  logic [4:0] r_px;
  logic [4:0] r_py;
  logic       r_border_s1;
  logic       r_valid_s1;
  // Stage 2
  logic [4:0] r_x_pos;
  logic [4:0] r_y_pos;
  logic       r_hsync_s2;
  logic       r_vsync_s2;
  logic       r_de_s2;
  logic       r_border_s2;
  logic       r_valid_s2;
  // Stage 3
  logic       r_hsync_s3;
  logic       r_vsync_s3;
  logic       r_de_s3;
  logic       r_border_s3;

  always_ff @(posedge i_vgaclk) begin
    if (i_rst) begin
      r_map_addr  <= '0;
      r_px        <= '0;
      r_py        <= '0;
      r_border_s1 <= 1'b0;
      r_valid_s1  <= 1'b0;
      r_x_pos     <= '0;
      r_y_pos     <= '0;
      r_hsync_s2  <= 1'b1;
      r_vsync_s2  <= 1'b1;
      r_de_s2     <= 1'b0;
      r_border_s2 <= 1'b0;
      r_valid_s2  <= 1'b0;
      r_hsync_s3  <= 1'b1;
      r_vsync_s3  <= 1'b1;
      r_de_s3     <= 1'b0;
      r_border_s3 <= 1'b0;
    end else begin
      r_map_addr  <= {w_map_y, w_h_cnt[TILE_SHIFT +: 4]};
      r_px        <= w_h_cnt[TILE_SHIFT-1:0];
      r_py        <= w_v_cnt[TILE_SHIFT-1:0];
      r_border_s1 <= w_in_border;
      r_valid_s1  <= 1'b1;

      r_x_pos     <= r_px;
      r_y_pos     <= r_py;
      r_hsync_s2  <= w_hsync_raw;
      r_vsync_s2  <= w_vsync_raw;
      r_de_s2     <= w_active;
      r_border_s2 <= r_border_s1;
      r_valid_s2  <= r_valid_s1;

      r_hsync_s3  <= r_hsync_s2;
      r_vsync_s3  <= r_vsync_s2;
      r_de_s3     <= r_de_s2;
      r_border_s3 <= r_border_s2;
    end
  end

  // The map RAM's own output register acts as the stage-2 register for the
  // tile code. r_valid_s2 hides RAM data fetched before reset released, and
  // border pixels are painted as ground.
  always_comb begin
    o_type = tile_to_type(TILE_GROUND);
    if (r_valid_s2 && !r_border_s2) begin
      o_type = tile_to_type(tile_e'(i_map_data));
    end
  end

  assign o_map_addr = r_map_addr;
  assign o_x_pos    = r_x_pos;
  assign o_y_pos    = r_y_pos;
  assign o_hsync    = r_hsync_s3;
  assign o_vsync    = r_vsync_s3;
  assign o_de       = r_de_s3;
  assign o_border   = r_border_s3;

endmodule

// File: tb/tb_vga_tile_scan.sv
`timescale 1ns/1ps
module tb_vga_tile_scan;

  localparam int HT = 800;
  localparam int VT = 525;
  localparam int FT = HT * VT;
`ifdef VGA_TILE_SCAN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] map_addr;
  logic [3:0] map_data = 4'd0;
  logic [4:0] typ, x_pos, y_pos;
  logic       hsync, vsync, de, border, frame_tick;
  logic [3:0] mem [256];

  always #5 clk = ~clk;

  vga_tile_scan dut (
    .i_vgaclk     (clk),
    .i_rst        (rst),
    .o_map_addr   (map_addr),
    .i_map_data   (map_data),
    .o_type       (typ),
    .o_x_pos      (x_pos),
    .o_y_pos      (y_pos),
    .o_hsync      (hsync),
    .o_vsync      (vsync),
    .o_de         (de),
    .o_border     (border),
    .o_frame_tick (frame_tick)
  );

  // Synchronous map RAM: data valid one cycle after the address.
  always @(posedge clk) map_data <= mem[map_addr];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---- reference model: raster position index n = v*800 + h ----
  function automatic int hh(input int n); return n % HT; endfunction
  function automatic int vv(input int n); return n / HT; endfunction
  function automatic int addr_of(input int n);
    int row;
    row = (vv(n) < 480) ? vv(n) / 32 : 0;
    return row * 16 + (hh(n) / 32) % 16;
  endfunction
  function automatic int e_hs(input int n);
    return (hh(n) >= 656 && hh(n) < 752) ? 0 : 1;
  endfunction
  function automatic int e_vs(input int n);
    return (vv(n) >= 490 && vv(n) < 492) ? 0 : 1;
  endfunction
  function automatic int e_de(input int n);
    return (hh(n) < 640 && vv(n) < 480) ? 1 : 0;
  endfunction
  function automatic int e_bd(input int n);
    return (BORDER && e_de(n) == 1 && hh(n) >= 512) ? 1 : 0;
  endfunction
  function automatic int e_type(input int n);
    return (e_bd(n) == 1) ? 0 : int'(mem[addr_of(n)]);
  endfunction

  // n_now: counter position now; hist[k]: position k+1 cycles ago (-1 = reset)
  int n_now = 0;
  int hist [3] = '{-1, -1, -1};
  bit ft_exp = 1'b0;
  bit started = 1'b0;
  int quiet = 0;

  always @(posedge clk) begin
    if (rst) begin
      n_now = 0;
      hist = '{-1, -1, -1};
      ft_exp = 1'b0;
      started = 1'b1;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = n_now;
      n_now = (n_now + 1) % FT;
      ft_exp = (n_now == 480 * HT);
    end
  end

  // ---- per-cycle compare ----
  bit prev_hs = 1'b1, prev_vs = 1'b1;
  int hs_run = -1, vs_run = -1;

  always @(negedge clk) begin
    if (started) begin
      check("h_cnt", int'(dut.u_counter.o_h_cnt), hh(n_now));
      check("v_cnt", int'(dut.u_counter.o_v_cnt), vv(n_now));
      check("frame_tick", int'(frame_tick), int'(ft_exp));
      check("map_addr", int'(map_addr), (hist[0] < 0) ? 0 : addr_of(hist[0]));
      check("type", int'(typ), (hist[1] < 0) ? 0 : e_type(hist[1]));
      check("x_pos", int'(x_pos), (hist[1] < 0) ? 0 : hh(hist[1]) % 32);
      check("y_pos", int'(y_pos), (hist[1] < 0) ? 0 : vv(hist[1]) % 32);
      check("hsync", int'(hsync), (hist[2] < 0) ? 1 : e_hs(hist[2]));
      check("vsync", int'(vsync), (hist[2] < 0) ? 1 : e_vs(hist[2]));
      check("de", int'(de), (hist[2] < 0) ? 0 : e_de(hist[2]));
      check("border", int'(border), (hist[2] < 0) ? 0 : e_bd(hist[2]));

      // hand-computed anchors
      if (hist[0] == 70 * HT + 37) check("lit_addr_h37_v70", int'(map_addr), 8'h21);
      if (hist[1] == 70 * HT + 37) begin
        check("lit_type_h37_v70", int'(typ), 1);
        check("lit_xpos_h37_v70", int'(x_pos), 5);
        check("lit_ypos_h37_v70", int'(y_pos), 6);
      end
      if (hist[2] == 0)   check("lit_de_rise", int'(de), 1);
      if (hist[2] == 639) check("lit_de_last", int'(de), 1);
      if (hist[2] == 640) check("lit_de_fall", int'(de), 0);
      if (hist[2] == 520) check("lit_border_h520", int'(border), BORDER ? 1 : 0);
      if (hist[1] == 520) check("lit_type_h520", int'(typ), BORDER ? 0 : 15);
      if (n_now == 480 * HT) check("lit_frame_tick", int'(frame_tick), 1);
      if (hist[0] == 0 && hist[1] == FT - 1) check("lit_wrap_addr", int'(map_addr), 0);

      // sync pulse widths, measured only over undisturbed stretches
      if (quiet > 0) begin
        quiet--;
        hs_run = -1;
        vs_run = -1;
      end else begin
        if (!hsync) begin
          if (prev_hs) hs_run = 1;
          else if (hs_run > 0) hs_run++;
        end else if (!prev_hs && hs_run > 0) begin
          check("hsync_width", hs_run, 96);
          hs_run = -1;
        end
        if (!vsync) begin
          if (prev_vs) vs_run = 1;
          else if (vs_run > 0) vs_run++;
        end else if (!prev_vs && vs_run > 0) begin
          check("vsync_width", vs_run, 1600);
          vs_run = -1;
        end
      end
      prev_hs = hsync;
      prev_vs = vsync;
    end
  end

  // ---- stimulus ----
  logic [9:0] jump_h, jump_v;

  task automatic jump_to(input int n);
    @(negedge clk);
    #2;
    jump_h = 10'(n % HT);
    jump_v = 10'(n / HT);
    force dut.u_counter.r_h_cnt = jump_h;
    force dut.u_counter.r_v_cnt = jump_v;
    n_now = n;
    quiet = 5;
    #1;
    release dut.u_counter.r_h_cnt;
    release dut.u_counter.r_v_cnt;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[8'h21] = 4'h1;
    mem[8'h00] = 4'hF;

    rst = 1'b1;
    run(3);
    rst = 1'b0;
    quiet = 5;
    run(3 * HT);

    // reset in the middle of an hsync pulse
    guard = 0;
    while (hh(n_now) != 700 && guard < 2 * HT) begin
      @(negedge clk);
      guard++;
    end
    if (hh(n_now) != 700) check("wait_h700_timeout", guard, 0);
    rst = 1'b1;
    quiet = 5;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_hsync", int'(hsync), 1);
    check("mid_rst_de", int'(de), 0);
    check("mid_rst_h_cnt", int'(dut.u_counter.o_h_cnt), 0);
    run(2 * HT);

    // random reset pulses
    repeat (2) begin
      run($urandom_range(50, 1500));
      rst = 1'b1;
      quiet = 5;
      run($urandom_range(1, 3));
      rst = 1'b0;
    end
    run(HT);

    jump_to(70 * HT + 20);
    run(30);
    jump_to(479 * HT + 780);
    run(40);
    jump_to(489 * HT + 600);
    run(3 * HT + 200);
    jump_to(FT - 20);
    run(40);
    repeat (4) begin
      jump_to($urandom_range(0, FT - 1));
      run($urandom_range(100, 900));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
